// File: rtl/m_drop_controller_if.sv
// Move-request handshake between the game front end and m_drop_controller.
// Also supplies default widths for the board-geometry macros if no shared header set them.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 3
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif

interface m_drop_controller_if;
    logic                 req_valid;
    logic [`COL_SIZE-1:0] req_col;
    logic                 req_ready;

    modport master (output req_valid, output req_col, input req_ready);
    modport slave  (input req_valid, input req_col, output req_ready);
endinterface

// File: rtl/m_drop_controller.sv
// Connect-four move controller: accepts a column, consults the external piled-counter stage,
// optionally animates the fall (define DROP_ANIM_EN), then commits the piece and swaps player.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 3
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif

module m_drop_controller #(
    parameter int NUM_COLS   = 7,
    parameter int NUM_ROWS   = 6,
    parameter int FALL_TICKS = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_clear,
    m_drop_controller_if.slave                 req,
    input  logic                               i_tick,
    output logic [`PILED_COUNT_ARRAY_SIZE-1:0] o_piled_count_array,
    output logic [`COL_SIZE-1:0]               o_col,
    input  logic                               i_pc_valid,
    input  logic [`PILED_COUNT_ARRAY_SIZE-1:0] i_pc_counter,
    input  logic [`ROW_SIZE-1:0]               i_pc_count,
    output logic [NUM_COLS*NUM_ROWS-1:0]       o_board_p0,
    output logic [NUM_COLS*NUM_ROWS-1:0]       o_board_p1,
    output logic                               o_player,
    output logic                               o_fall_active,
    output logic [`ROW_SIZE-1:0]               o_fall_row,
    output logic                               o_done,
    output logic [`ROW_SIZE-1:0]               o_done_row,
    output logic                               o_reject,
    output logic                               o_board_full
);

    localparam int FIELD_W    = 3;
    localparam int BOARD_BITS = NUM_COLS * NUM_ROWS;
    localparam int IDX_W      = 7;
    localparam logic [`COL_SIZE-1:0] LAST_COL = `COL_SIZE'(NUM_COLS - 1);

    typedef enum logic [2:0] {IDLE, CHECK, FALL, COMMIT, REJECT} state_t;

    state_t                             state_q, state_d;
    logic [`COL_SIZE-1:0]               col_q, col_d;
    logic [`PILED_COUNT_ARRAY_SIZE-1:0] array_q, array_d;
    logic [`PILED_COUNT_ARRAY_SIZE-1:0] next_array_q, next_array_d;
    logic [`ROW_SIZE-1:0]               target_q, target_d;
    logic [`ROW_SIZE-1:0]               fall_row_q, fall_row_d;
    logic [`ROW_SIZE-1:0]               done_row_q, done_row_d;
    logic [BOARD_BITS-1:0]              board_p0_q, board_p0_d;
    logic [BOARD_BITS-1:0]              board_p1_q, board_p1_d;
    logic [BOARD_BITS-1:0]              commit_mask;
    logic [IDX_W-1:0]                   commit_idx;
    logic                               player_q, player_d;
    logic                               board_full;

`ifdef DROP_ANIM_EN
    localparam int TICK_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FALL_TICKS - 1);
    localparam logic [`ROW_SIZE-1:0] TOP_ROW = `ROW_SIZE'(NUM_ROWS - 1);
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
`else
    localparam int unused_fall_ticks = FALL_TICKS;
    logic unused_tick;
    assign unused_tick = i_tick;
`endif

    // Index is wide enough that row*NUM_COLS+col never wraps for the largest cell.
    always_comb begin
        commit_idx  = IDX_W'(target_q) * IDX_W'(NUM_COLS) + IDX_W'(col_q);
        commit_mask = BOARD_BITS'(1) << commit_idx;
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        array_d      = array_q;
        next_array_d = next_array_q;
        target_d     = target_q;
        fall_row_d   = fall_row_q;
        done_row_d   = done_row_q;
        board_p0_d   = board_p0_q;
        board_p1_d   = board_p1_q;
        player_d     = player_q;
`ifdef DROP_ANIM_EN
        tick_cnt_d   = tick_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    col_d   = req.req_col;
                    state_d = (req.req_col > LAST_COL) ? REJECT : CHECK;
                end
            end
            CHECK: begin
                if (!i_pc_valid) begin
                    state_d = REJECT;
                end else begin
                    next_array_d = i_pc_counter;
                    target_d     = i_pc_count;
`ifdef DROP_ANIM_EN
                    fall_row_d   = TOP_ROW;
                    tick_cnt_d   = '0;
                    state_d      = FALL;
`else
                    fall_row_d   = i_pc_count;
                    done_row_d   = i_pc_count;
                    state_d      = COMMIT;
`endif
                end
            end
            FALL: begin
`ifdef DROP_ANIM_EN
                if (i_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (fall_row_q == target_q) begin
                            done_row_d = target_q;
                            state_d    = COMMIT;
                        end else begin
                            fall_row_d = fall_row_q - `ROW_SIZE'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            COMMIT: begin
                array_d = next_array_q;
                if (player_q) begin
                    board_p1_d = board_p1_q | commit_mask;
                end else begin
                    board_p0_d = board_p0_q | commit_mask;
                end
                player_d = ~player_q;
                state_d  = IDLE;
            end
            REJECT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new-game request overrides whatever move is in flight, including a same-cycle request.
        if (i_clear) begin
            state_d    = IDLE;
            col_d      = col_q;
            array_d    = '0;
            board_p0_d = '0;
            board_p1_d = '0;
            player_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            array_q      <= '0;
            next_array_q <= '0;
            target_q     <= '0;
            fall_row_q   <= '0;
            done_row_q   <= '0;
            board_p0_q   <= '0;
            board_p1_q   <= '0;
            player_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            array_q      <= array_d;
            next_array_q <= next_array_d;
            target_q     <= target_d;
            fall_row_q   <= fall_row_d;
            done_row_q   <= done_row_d;
            board_p0_q   <= board_p0_d;
            board_p1_q   <= board_p1_d;
            player_q     <= player_d;
        end
    end

`ifdef DROP_ANIM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end
`endif

    always_comb begin
        board_full = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (array_q[c*FIELD_W +: FIELD_W] != FIELD_W'(NUM_ROWS)) begin
                board_full = 1'b0;
            end
        end
    end

    assign req.req_ready         = (state_q == IDLE);
    assign o_piled_count_array   = array_q;
    assign o_col                 = col_q;
    assign o_board_p0            = board_p0_q;
    assign o_board_p1            = board_p1_q;
    assign o_player              = player_q;
`ifdef DROP_ANIM_EN
    assign o_fall_active         = (state_q == FALL);
`else
    assign o_fall_active         = 1'b0;
`endif
    assign o_fall_row            = fall_row_q;
    assign o_done                = (state_q == COMMIT);
    assign o_done_row            = done_row_q;
    assign o_reject              = (state_q == REJECT);
    assign o_board_full          = board_full;

endmodule

// File: tb/tb_m_drop_controller.sv
// Table-driven bench for m_drop_controller with a behavioural piled-counter stage.
// Animation checks are compiled only when DROP_ANIM_EN is defined.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef ROW_SIZE
`define ROW_SIZE 3
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif

module tb_m_drop_controller;

    localparam int BUDGET = 200;

    typedef struct {
        logic [2:0] col;
        logic       exp_reject;
        logic [2:0] exp_row;
        logic       exp_player;
        int         exp_cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        tick;
    logic [2:0]  dut_col;
    logic [20:0] pc_array;
    logic [20:0] pc_counter;
    logic        pc_valid;
    logic [2:0]  pc_count;
    logic [41:0] board_p0;
    logic [41:0] board_p1;
    logic        player;
    logic        fall_active;
    logic [2:0]  fall_row;
    logic        done;
    logic [2:0]  done_row;
    logic        reject;
    logic        board_full;

    int n_vectors     = 0;
    int n_miscompares = 0;

    m_drop_controller_if req_if();

    m_drop_controller #(
        .NUM_COLS  (7),
        .NUM_ROWS  (6),
        .FALL_TICKS(2)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_clear            (clear),
        .req                (req_if),
        .i_tick             (tick),
        .o_piled_count_array(pc_array),
        .o_col              (dut_col),
        .i_pc_valid         (pc_valid),
        .i_pc_counter       (pc_counter),
        .i_pc_count         (pc_count),
        .o_board_p0         (board_p0),
        .o_board_p1         (board_p1),
        .o_player           (player),
        .o_fall_active      (fall_active),
        .o_fall_row         (fall_row),
        .o_done             (done),
        .o_done_row         (done_row),
        .o_reject           (reject),
        .o_board_full       (board_full)
    );

    always #5 clk = ~clk;

    // Reference piled-counter stage: landing row is the old count, valid while below six.
    always_comb begin
        pc_valid   = 1'b0;
        pc_counter = pc_array;
        pc_count   = 3'd0;
        for (int c = 0; c < 7; c++) begin
            if (c == int'(dut_col)) begin
                pc_count              = pc_array[c*3 +: 3];
                pc_valid              = (pc_array[c*3 +: 3] < 3'd6);
                pc_counter[c*3 +: 3]  = pc_array[c*3 +: 3] + 3'd1;
            end
        end
    end

    // Display frame pulse: one cycle high every three cycles.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one request and waits (bounded) for the done or reject pulse, then one more cycle.
    task automatic applyStimulus(input logic [2:0] col, output logic saw_done, output logic saw_reject,
                                 output logic [2:0] row, output int cycles);
        saw_done   = 1'b0;
        saw_reject = 1'b0;
        row        = 3'd0;
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_col   = col;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        cycles = 1;
        while (!(done || reject) && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        if (done) begin
            saw_done = 1'b1;
            row      = done_row;
        end
        if (reject) begin
            saw_reject = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[9];
        logic        sd;
        logic        sr;
        logic [2:0]  row;
        int          cyc;
        int          pulses;
`ifdef DROP_ANIM_EN
        int          n;
        logic [2:0]  last;
        int          seq_rows[$];
        int          seq_cyc[$];
`endif

        rst_n            = 1'b0;
        clear            = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_col   = 3'd0;

        vecs[0] = '{3'd0, 1'b0, 3'd0, 1'b1, 2};
        vecs[1] = '{3'd0, 1'b0, 3'd1, 1'b0, 2};
        vecs[2] = '{3'd0, 1'b0, 3'd2, 1'b1, 2};
        vecs[3] = '{3'd0, 1'b0, 3'd3, 1'b0, 2};
        vecs[4] = '{3'd0, 1'b0, 3'd4, 1'b1, 2};
        vecs[5] = '{3'd0, 1'b0, 3'd5, 1'b0, 2};
        vecs[6] = '{3'd0, 1'b1, 3'd0, 1'b0, 2};
        vecs[7] = '{3'd7, 1'b1, 3'd0, 1'b0, 1};
        vecs[8] = '{3'd6, 1'b0, 3'd0, 1'b1, 2};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        checkOutput("reset ready", 64'(req_if.req_ready), 64'd1);
        checkOutput("reset array", 64'(pc_array), 64'd0);
        checkOutput("reset p0", 64'(board_p0), 64'd0);
        checkOutput("reset p1", 64'(board_p1), 64'd0);
        checkOutput("reset player", 64'(player), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset reject", 64'(reject), 64'd0);
        checkOutput("reset fall_row", 64'(fall_row), 64'd0);
        checkOutput("reset done_row", 64'(done_row), 64'd0);
        checkOutput("reset board_full", 64'(board_full), 64'd0);
        checkOutput("reset fall_active", 64'(fall_active), 64'd0);

        // First move into column 3 lands on row 0 for player 0.
        applyStimulus(3'd3, sd, sr, row, cyc);
        checkOutput("col3 done", 64'(sd), 64'd1);
        checkOutput("col3 reject", 64'(sr), 64'd0);
        checkOutput("col3 done_row", 64'(row), 64'd0);
`ifndef DROP_ANIM_EN
        checkOutput("col3 latency", 64'(cyc), 64'd2);
`endif
        checkOutput("col3 p0", 64'(board_p0), 64'h8);
        checkOutput("col3 p1", 64'(board_p1), 64'd0);
        checkOutput("col3 array", 64'(pc_array), 64'h000200);
        checkOutput("col3 player", 64'(player), 64'd1);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clear array", 64'(pc_array), 64'd0);
        checkOutput("clear p0", 64'(board_p0), 64'd0);
        checkOutput("clear player", 64'(player), 64'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].col, sd, sr, row, cyc);
            checkOutput($sformatf("vec%0d done", i), 64'(sd), 64'(!vecs[i].exp_reject));
            checkOutput($sformatf("vec%0d reject", i), 64'(sr), 64'(vecs[i].exp_reject));
            if (!vecs[i].exp_reject) begin
                checkOutput($sformatf("vec%0d done_row", i), 64'(row), 64'(vecs[i].exp_row));
            end
`ifdef DROP_ANIM_EN
            if (vecs[i].exp_reject) begin
                checkOutput($sformatf("vec%0d latency", i), 64'(cyc), 64'(vecs[i].exp_cycles));
            end
`else
            checkOutput($sformatf("vec%0d latency", i), 64'(cyc), 64'(vecs[i].exp_cycles));
`endif
            checkOutput($sformatf("vec%0d player", i), 64'(player), 64'(vecs[i].exp_player));
        end
        checkOutput("table array", 64'(pc_array), 64'h040006);
        checkOutput("table p0", 64'(board_p0), (64'd1 << 0) | (64'd1 << 6) | (64'd1 << 14) | (64'd1 << 28));
        checkOutput("table p1", 64'(board_p1), (64'd1 << 7) | (64'd1 << 21) | (64'd1 << 35));

        // Clear arriving while the request is in CHECK abandons the move and wipes the game.
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_col   = 3'd2;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        checkOutput("clrchk busy", 64'(req_if.req_ready), 64'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clrchk ready", 64'(req_if.req_ready), 64'd1);
        checkOutput("clrchk done", 64'(done), 64'd0);
        checkOutput("clrchk array", 64'(pc_array), 64'd0);
        checkOutput("clrchk p0", 64'(board_p0), 64'd0);
        checkOutput("clrchk p1", 64'(board_p1), 64'd0);
        checkOutput("clrchk player", 64'(player), 64'd0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || reject) pulses++;
        end
        checkOutput("clrchk no pulse", 64'(pulses), 64'd0);

        // A request in the same cycle as clear is dropped.
        clear            = 1'b1;
        req_if.req_valid = 1'b1;
        req_if.req_col   = 3'd4;
        @(negedge clk);
        clear            = 1'b0;
        req_if.req_valid = 1'b0;
        checkOutput("clrreq ready", 64'(req_if.req_ready), 64'd1);
        checkOutput("clrreq col", 64'(dut_col), 64'd2);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || reject || !req_if.req_ready) pulses++;
        end
        checkOutput("clrreq idle", 64'(pulses), 64'd0);
        checkOutput("clrreq array", 64'(pc_array), 64'd0);

`ifdef DROP_ANIM_EN
        // Column 5 falls from row 5 to row 0, one row per two ticks (six cycles).
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_col   = 3'd5;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        n = 1;
        while (!fall_active && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("anim fall_active", 64'(fall_active), 64'd1);
        last = fall_row;
        seq_rows.push_back(int'(last));
        seq_cyc.push_back(n);
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (fall_active && fall_row !== last) begin
                last = fall_row;
                seq_rows.push_back(int'(last));
                seq_cyc.push_back(n);
            end
        end
        checkOutput("anim done", 64'(done), 64'd1);
        checkOutput("anim done_row", 64'(done_row), 64'd0);
        checkOutput("anim steps", 64'(seq_rows.size()), 64'd6);
        for (int k = 0; k < seq_rows.size() && k < 6; k++) begin
            checkOutput($sformatf("anim row%0d", k), 64'(seq_rows[k]), 64'(5 - k));
        end
        for (int k = 2; k < seq_cyc.size(); k++) begin
            checkOutput($sformatf("anim gap%0d", k), 64'(seq_cyc[k] - seq_cyc[k-1]), 64'd6);
        end
        @(negedge clk);
        checkOutput("anim p0", 64'(board_p0), 64'h20);
        checkOutput("anim player", 64'(player), 64'd1);

        // Clear in mid-FALL at row 3.
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_col   = 3'd1;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        n = 1;
        while (!(fall_active && fall_row == 3'd3) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midfall row", 64'(fall_row), 64'd3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("midfall ready", 64'(req_if.req_ready), 64'd1);
        checkOutput("midfall active", 64'(fall_active), 64'd0);
        checkOutput("midfall p0", 64'(board_p0), 64'd0);
        checkOutput("midfall p1", 64'(board_p1), 64'd0);
        checkOutput("midfall array", 64'(pc_array), 64'd0);
        checkOutput("midfall player", 64'(player), 64'd0);
        checkOutput("midfall done", 64'(done), 64'd0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("midfall no done", 64'(pulses), 64'd0);
`endif

        // Fill the board row by row across all columns; players alternate per commit.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (r == 5 && c == 6) begin
                    checkOutput("fill not full yet", 64'(board_full), 64'd0);
                end
                applyStimulus(3'(c), sd, sr, row, cyc);
                checkOutput($sformatf("fill r%0d c%0d done", r, c), 64'(sd), 64'd1);
                checkOutput($sformatf("fill r%0d c%0d row", r, c), 64'(row), 64'(r));
            end
        end
        checkOutput("fill board_full", 64'(board_full), 64'd1);
        checkOutput("fill array", 64'(pc_array), 64'(21'o6666666));
        checkOutput("fill p0", 64'(board_p0), 64'h155_5555_5555);
        checkOutput("fill p1", 64'(board_p1), 64'h2AA_AAAA_AAAA);
        checkOutput("fill player", 64'(player), 64'd0);

        applyStimulus(3'd2, sd, sr, row, cyc);
        checkOutput("full reject", 64'(sr), 64'd1);
        checkOutput("full done", 64'(sd), 64'd0);
        checkOutput("full latency", 64'(cyc), 64'd2);
        checkOutput("full player", 64'(player), 64'd0);
        checkOutput("full p0", 64'(board_p0), 64'h155_5555_5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
